sdram_init_monitor: RTL and testbench
=====================================

// Module: sdram_init_monitor
// PURPOSE
//  Parametrised cycle-accurate checker for the SDRAM power-up sequence: NOP hold,
//  PRECHARGE, N x AUTO-REFRESH, optional LOAD MODE REGISTER. Sits beside the
//  controller on the SDRAM command pins. Reports done/error and latches the
//  programmed mode word. Adds to the old init check: configurable refresh count,
//  tRFC spacing, LMR check, error classification.
// PARAMETERS
//  NOP_MIN_CYC   500  consecutive NOP cycles required after reset release
//  STEP_MAX_GAP  100  max NOP cycles between one step and the next expected command
//  NUM_AREF      2    AUTO-REFRESH commands required (1..15)
//  T_RFC         8    min cycles between consecutive AUTO-REFRESH commands
//  CHECK_LMR     1    1: LMR must follow the last AREF; 0: sequence ends at last AREF
//  SDR_ADDR_W    13   width of sdr_addr
// PORTS
//  sdram_clk     in   1           SDRAM clock; all sampling on FALLING edge
//  sdram_resetn  in   1           async active-low reset
//  sdr_cs_n      in   1           chip select
//  sdr_ras_n     in   1           row strobe
//  sdr_cas_n     in   1           column strobe
//  sdr_we_n      in   1           write enable
//  sdr_addr      in   SDR_ADDR_W  address bus; mode word during LMR
//  init_done     out  1           sequence completed without error (sticky)
//  init_err      out  1           sequence violated (sticky)
//  err_code      out  3           0 none,1 early cmd,2 wrong cmd,3 timeout,4 tRFC,5 illegal
//  aref_cnt      out  4           AUTO-REFRESH commands accepted so far
//  mode_reg      out  SDR_ADDR_W  sdr_addr captured at the LMR command
// BEHAVIOUR
//  Reset: one clock; reset async active-low. While sdram_resetn=0: all outputs 0,
//   FSM=NOP_WAIT, counters 0. Reset may assert at any time (mid-sequence, after
//   DONE/ERR); sequence restarts from NOP_WAIT.
//  Decode per sampled cycle: cs_n=1 or {ras,cas,we}=111 -> NOP; 010 -> PRE;
//   001 -> AREF; 000 -> LMR; any other encoding -> ILLEGAL.
//  A command held on consecutive cycles counts once (first cycle only); a change
//   to a different non-NOP command without an intervening NOP is a new command.
//  gap_cnt: cleared on every accepted step; +1 per NOP cycle.
//  FSM states and transitions:
//   NOP_WAIT: count NOPs; any non-NOP before count reaches NOP_MIN_CYC -> ERR
//    (code 1). At NOP_MIN_CYC -> WAIT_PRE, gap_cnt=0.
//   WAIT_PRE: PRE -> WAIT_AREF. AREF/LMR -> ERR(2).
//   WAIT_AREF: AREF -> aref_cnt+1; if aref_cnt+1==NUM_AREF go to WAIT_LMR
//    (CHECK_LMR=1) or DONE. Second and later AREF with gap_cnt<T_RFC-1 -> ERR(4).
//    PRE/LMR -> ERR(2).
//   WAIT_LMR: LMR -> mode_reg<=sdr_addr, DONE. PRE/AREF -> ERR(2).
//   Any WAIT_* state: gap_cnt reaching STEP_MAX_GAP+1 with no expected cmd -> ERR(3).
//   Any state except DONE: ILLEGAL encoding -> ERR(5).
//   DONE: init_done=1; all further commands ignored.
//   ERR: init_err=1, err_code frozen at first error; only reset exits.
//  Latency: init_done/init_err/err_code/mode_reg update at the same falling edge
//   that samples the deciding command; visible immediately after it.
//  Priority in one cycle: ILLEGAL (5) over all other errors; timeout checked
//   before the command sampled on that cycle.
//  init_done and init_err never both 1. Counters saturate and never wrap.
// TESTING
//  Defaults (500/100/2/8/1). Reset, 500 NOP, PRE at gap 10, AREF at gap 20,
//   AREF at gap 20, LMR addr=0x033 at gap 5 -> init_done=1, aref_cnt=2, mode_reg=0x033.
//  AREF on NOP cycle 300 -> init_err=1, err_code=1, init_done stays 0.
//  PRE then 101 NOP cycles with no AREF -> err_code=3 on 101st NOP; gap 100 passes.
//  Second AREF 4 cycles after first (T_RFC=8) -> err_code=4.
//  {ras,cas,we}=011 with cs_n=0 during WAIT_AREF -> err_code=5; cs_n=1 same pins -> NOP, ok.
//  Drop sdram_resetn mid-WAIT_AREF, then full legal sequence -> outputs 0 during
//   reset, then init_done=1; CHECK_LMR=0, NUM_AREF=4 -> done at 4th AREF, mode_reg=0.

Source files
------------

// File: rtl/sdram_init_monitor.sv
// Passive checker for the SDRAM power-up command sequence (NOP hold, PRECHARGE,
// N x AUTO-REFRESH, optional LOAD MODE REGISTER), sampling the command pins on the falling edge.
module sdram_init_monitor #(
   parameter int unsigned NOP_MIN_CYC  = 500,
   parameter int unsigned STEP_MAX_GAP = 100,
   parameter int unsigned NUM_AREF     = 2,
   parameter int unsigned T_RFC        = 8,
   parameter int unsigned CHECK_LMR    = 1,
   parameter int unsigned SDR_ADDR_W   = 13
) (
   input  logic                  sdram_clk,
   input  logic                  sdram_resetn,
   input  logic                  sdr_cs_n,
   input  logic                  sdr_ras_n,
   input  logic                  sdr_cas_n,
   input  logic                  sdr_we_n,
   input  logic [SDR_ADDR_W-1:0] sdr_addr,
   output logic                  init_done,
   output logic                  init_err,
   output logic [2:0]            err_code,
   output logic [3:0]            aref_cnt,
   output logic [SDR_ADDR_W-1:0] mode_reg
);

   localparam int unsigned NOP_W   = (NOP_MIN_CYC > 1) ? $clog2(NOP_MIN_CYC + 1) : 1;
   localparam int unsigned GAP_MAX = (STEP_MAX_GAP + 1 > T_RFC) ? STEP_MAX_GAP + 1 : T_RFC;
   localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

   localparam logic [NOP_W-1:0] NOP_LAST  = NOP_W'(NOP_MIN_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(STEP_MAX_GAP);
   localparam logic [GAP_W-1:0] RFC_MIN   = GAP_W'(T_RFC - 1);
   localparam logic [3:0]       AREF_TGT  = 4'(NUM_AREF);

   localparam logic [2:0] ERR_EARLY   = 3'd1;
   localparam logic [2:0] ERR_WRONG   = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_TRFC    = 3'd4;
   localparam logic [2:0] ERR_ILLEGAL = 3'd5;

   typedef enum logic [2:0] {
      S_NOP_WAIT, S_WAIT_PRE, S_WAIT_AREF, S_WAIT_LMR, S_DONE, S_ERR
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_PRE, C_AREF, C_LMR, C_ILL
   } cmd_t;

   state_t                  state_q, state_d;
   cmd_t                    cmd, cmd_prev_q, cmd_prev_d;
   logic [NOP_W-1:0]        nop_cnt_q, nop_cnt_d;
   logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
   logic [3:0]              aref_cnt_q, aref_cnt_d;
   logic [2:0]              err_code_q, err_code_d;
   logic [SDR_ADDR_W-1:0]   mode_reg_q, mode_reg_d;
   logic [3:0]              aref_inc;
   logic                    new_cmd;

   always_comb begin
      cmd = C_ILL;
      if (sdr_cs_n) begin
         cmd = C_NOP;
      end else begin
         case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
            3'b111:  cmd = C_NOP;
            3'b010:  cmd = C_PRE;
            3'b001:  cmd = C_AREF;
            3'b000:  cmd = C_LMR;
            default: cmd = C_ILL;
         endcase
      end
   end

   // A non-NOP that repeats the previous cycle's command is the same command held, not a new one.
   assign new_cmd  = (cmd != C_NOP) && (cmd != cmd_prev_q);
   assign aref_inc = (aref_cnt_q == 4'hF) ? 4'hF : aref_cnt_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      cmd_prev_d = cmd;
      nop_cnt_d  = nop_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      aref_cnt_d = aref_cnt_q;
      err_code_d = err_code_q;
      mode_reg_d = mode_reg_q;

      case (state_q)
         S_NOP_WAIT: begin
            if (cmd == C_ILL) begin
               state_d    = S_ERR;
               err_code_d = ERR_ILLEGAL;
            end else if (cmd != C_NOP) begin
               state_d    = S_ERR;
               err_code_d = ERR_EARLY;
            end else begin
               nop_cnt_d = nop_cnt_q + 1'b1;
               if (nop_cnt_q == NOP_LAST) begin
                  state_d   = S_WAIT_PRE;
                  gap_cnt_d = '0;
               end
            end
         end

         S_WAIT_PRE, S_WAIT_AREF, S_WAIT_LMR: begin
            if (cmd == C_ILL) begin
               state_d    = S_ERR;
               err_code_d = ERR_ILLEGAL;
            end else if (cmd == C_NOP) begin
               // The NOP that would push the gap past the limit is itself the timeout.
               if (gap_cnt_q >= GAP_LIMIT) begin
                  state_d    = S_ERR;
                  err_code_d = ERR_TIMEOUT;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end else if (new_cmd) begin
               state_d    = S_ERR;
               err_code_d = ERR_WRONG;
               if (state_q == S_WAIT_PRE && cmd == C_PRE) begin
                  state_d    = S_WAIT_AREF;
                  err_code_d = err_code_q;
                  gap_cnt_d  = '0;
               end else if (state_q == S_WAIT_AREF && cmd == C_AREF) begin
                  if (aref_cnt_q != 4'd0 && gap_cnt_q < RFC_MIN) begin
                     err_code_d = ERR_TRFC;
                  end else begin
                     err_code_d = err_code_q;
                     aref_cnt_d = aref_inc;
                     gap_cnt_d  = '0;
                     state_d    = S_WAIT_AREF;
                     if (aref_inc == AREF_TGT) begin
                        state_d = (CHECK_LMR != 0) ? S_WAIT_LMR : S_DONE;
                     end
                  end
               end else if (state_q == S_WAIT_LMR && cmd == C_LMR) begin
                  state_d    = S_DONE;
                  err_code_d = err_code_q;
                  mode_reg_d = sdr_addr;
                  gap_cnt_d  = '0;
               end
            end
         end

         default: begin
            state_d = state_q;
         end
      endcase
   end

   always_ff @(negedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         state_q    <= S_NOP_WAIT;
         cmd_prev_q <= C_NOP;
         nop_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         aref_cnt_q <= '0;
         err_code_q <= '0;
         mode_reg_q <= '0;
      end else begin
         state_q    <= state_d;
         cmd_prev_q <= cmd_prev_d;
         nop_cnt_q  <= nop_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         aref_cnt_q <= aref_cnt_d;
         err_code_q <= err_code_d;
         mode_reg_q <= mode_reg_d;
      end
   end

   assign init_done = (state_q == S_DONE);
   assign init_err  = (state_q == S_ERR);
   assign err_code  = err_code_q;
   assign aref_cnt  = aref_cnt_q;
   assign mode_reg  = mode_reg_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed bench for sdram_init_monitor: a vector table for the legal sequence plus hand-written
// error and reset sequences; a second instance covers NUM_AREF=4 without the LMR step.
module tb_sdram_init_monitor;

   localparam int AW = 13;
   localparam logic [3:0] P_NOP   = 4'b0111;
   localparam logic [3:0] P_PRE   = 4'b0010;
   localparam logic [3:0] P_AREF  = 4'b0001;
   localparam logic [3:0] P_LMR   = 4'b0000;
   localparam logic [3:0] P_ILL   = 4'b0011;
   localparam logic [3:0] P_DESEL = 4'b1011;

   logic          clk = 1'b0;
   logic          rst1_n, rst2_n;
   logic          cs_n, ras_n, cas_n, we_n;
   logic [AW-1:0] addr;

   logic          done1, err1, done2, err2;
   logic [2:0]    code1, code2;
   logic [3:0]    aref1, aref2;
   logic [AW-1:0] mode1, mode2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sdram_init_monitor u_dut (
      .sdram_clk(clk), .sdram_resetn(rst1_n),
      .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
      .sdr_addr(addr),
      .init_done(done1), .init_err(err1), .err_code(code1),
      .aref_cnt(aref1), .mode_reg(mode1)
   );

   sdram_init_monitor #(.NUM_AREF(4), .CHECK_LMR(0)) u_dut4 (
      .sdram_clk(clk), .sdram_resetn(rst2_n),
      .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
      .sdr_addr(addr),
      .init_done(done2), .init_err(err2), .err_code(code2),
      .aref_cnt(aref2), .mode_reg(mode2)
   );

   typedef struct {
      int            gap;
      logic [3:0]    pins;
      logic [AW-1:0] a;
      logic          done;
      logic          err;
      logic [2:0]    code;
      logic [3:0]    aref;
      logic [AW-1:0] mode;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check1(input string tag, input logic d, input logic e, input logic [2:0] c,
                         input logic [3:0] r, input logic [AW-1:0] m);
      check({tag, ".done"}, 32'(done1), 32'(d));
      check({tag, ".err"},  32'(err1),  32'(e));
      check({tag, ".code"}, 32'(code1), 32'(c));
      check({tag, ".aref"}, 32'(aref1), 32'(r));
      check({tag, ".mode"}, 32'(mode1), 32'(m));
   endtask

   task automatic check2(input string tag, input logic d, input logic e, input logic [2:0] c,
                         input logic [3:0] r, input logic [AW-1:0] m);
      check({tag, ".done"}, 32'(done2), 32'(d));
      check({tag, ".err"},  32'(err2),  32'(e));
      check({tag, ".code"}, 32'(code2), 32'(c));
      check({tag, ".aref"}, 32'(aref2), 32'(r));
      check({tag, ".mode"}, 32'(mode2), 32'(m));
   endtask

   // Drive pins between falling edges; outputs are read 1 time unit after the sampling edge.
   task automatic drive(input logic [3:0] pins, input logic [AW-1:0] a);
      @(posedge clk);
      {cs_n, ras_n, cas_n, we_n} = pins;
      addr = a;
      @(negedge clk);
      #1;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) drive(P_NOP, '0);
   endtask

   // Release happens at a rising edge with NOP on the pins, so that falling edge is NOP #1.
   task automatic reset_release(input bit which);
      @(posedge clk);
      if (which) rst2_n = 1'b0; else rst1_n = 1'b0;
      drive(P_PRE, 13'h1AB);
      drive(P_AREF, 13'h0F0);
      if (which) check2("in_reset", 1'b0, 1'b0, 3'd0, 4'd0, '0);
      else       check1("in_reset", 1'b0, 1'b0, 3'd0, 4'd0, '0);
      @(posedge clk);
      if (which) rst2_n = 1'b1; else rst1_n = 1'b1;
      {cs_n, ras_n, cas_n, we_n} = P_NOP;
      addr = '0;
      @(negedge clk);
      #1;
   endtask

   task automatic to_wait_pre(input bit which);
      reset_release(which);
      nops(499);
   endtask

   initial begin
      rst1_n = 1'b0;
      rst2_n = 1'b0;
      {cs_n, ras_n, cas_n, we_n} = P_NOP;
      addr = '0;

      //           gap  pins     addr      done  err   code  aref  mode
      tbl[0] = '{10,  P_PRE,   13'h000,  1'b0, 1'b0, 3'd0, 4'd0, 13'h000};
      tbl[1] = '{0,   P_PRE,   13'h000,  1'b0, 1'b0, 3'd0, 4'd0, 13'h000};
      tbl[2] = '{5,   P_DESEL, 13'h1FFF, 1'b0, 1'b0, 3'd0, 4'd0, 13'h000};
      tbl[3] = '{14,  P_AREF,  13'h000,  1'b0, 1'b0, 3'd0, 4'd1, 13'h000};
      tbl[4] = '{0,   P_AREF,  13'h000,  1'b0, 1'b0, 3'd0, 4'd1, 13'h000};
      tbl[5] = '{7,   P_AREF,  13'h000,  1'b0, 1'b0, 3'd0, 4'd2, 13'h000};
      tbl[6] = '{100, P_LMR,   13'h033,  1'b1, 1'b0, 3'd0, 4'd2, 13'h033};
      tbl[7] = '{3,   P_ILL,   13'h000,  1'b1, 1'b0, 3'd0, 4'd2, 13'h033};
      tbl[8] = '{2,   P_LMR,   13'h155,  1'b1, 1'b0, 3'd0, 4'd2, 13'h033};

      repeat (2) @(negedge clk);
      #1;
      check1("por", 1'b0, 1'b0, 3'd0, 4'd0, '0);
      check2("por4", 1'b0, 1'b0, 3'd0, 4'd0, '0);

      // Early command on NOP cycle 300.
      reset_release(1'b0);
      nops(298);
      drive(P_AREF, '0);
      check1("early300", 1'b0, 1'b1, 3'd1, 4'd0, '0);

      // PRE on NOP cycle 500 is still one cycle early.
      reset_release(1'b0);
      nops(498);
      drive(P_PRE, '0);
      check1("early500", 1'b0, 1'b1, 3'd1, 4'd0, '0);

      // AREF while PRE is expected.
      to_wait_pre(1'b0);
      drive(P_AREF, '0);
      check1("wrong_cmd", 1'b0, 1'b1, 3'd2, 4'd0, '0);

      // Timeout: 100 NOPs tolerated, the 101st is an error.
      to_wait_pre(1'b0);
      drive(P_PRE, '0);
      nops(100);
      check1("gap100", 1'b0, 1'b0, 3'd0, 4'd0, '0);
      drive(P_NOP, '0);
      check1("gap101", 1'b0, 1'b1, 3'd3, 4'd0, '0);

      // Second AREF 4 cycles after the first violates tRFC.
      to_wait_pre(1'b0);
      drive(P_PRE, '0);
      nops(3);
      drive(P_AREF, '0);
      nops(3);
      drive(P_AREF, '0);
      check1("trfc", 1'b0, 1'b1, 3'd4, 4'd1, '0);

      // Illegal encoding in WAIT_AREF; error stays frozen afterwards.
      to_wait_pre(1'b0);
      drive(P_PRE, '0);
      nops(2);
      drive(P_ILL, '0);
      check1("illegal", 1'b0, 1'b1, 3'd5, 4'd0, '0);
      drive(P_AREF, '0);
      drive(P_LMR, 13'h033);
      check1("err_sticky", 1'b0, 1'b1, 3'd5, 4'd0, '0);

      // Reset mid-WAIT_AREF, then the full legal sequence from the table.
      to_wait_pre(1'b0);
      drive(P_PRE, '0);
      nops(5);
      drive(P_AREF, '0);
      check1("mid_aref", 1'b0, 1'b0, 3'd0, 4'd1, '0);
      to_wait_pre(1'b0);
      for (int i = 0; i < 9; i++) begin
         nops(tbl[i].gap);
         drive(tbl[i].pins, tbl[i].a);
         check1($sformatf("row%0d", i), tbl[i].done, tbl[i].err, tbl[i].code,
                tbl[i].aref, tbl[i].mode);
      end
      check2("held4", 1'b0, 1'b0, 3'd0, 4'd0, '0);

      // NUM_AREF=4, no LMR step: done on the 4th AREF, mode word untouched.
      to_wait_pre(1'b1);
      nops(3);
      drive(P_PRE, '0);
      nops(3);
      drive(P_AREF, '0);
      for (int k = 2; k <= 3; k++) begin
         nops(7);
         drive(P_AREF, '0);
      end
      check2("aref3", 1'b0, 1'b0, 3'd0, 4'd3, '0);
      nops(7);
      drive(P_AREF, '0);
      check2("aref4", 1'b1, 1'b0, 3'd0, 4'd4, '0);
      drive(P_LMR, 13'h0AA);
      check2("lmr_ign", 1'b1, 1'b0, 3'd0, 4'd4, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
